// File: rtl/axis_img_source_pkg.sv
// Shared definitions for the image stream source: FSM encoding and AXI-Stream sideband tie-offs.
package axis_img_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } src_state_e;

    localparam logic AXIS_TID_TIE   = 1'b0;
    localparam logic AXIS_TDEST_TIE = 1'b0;
    localparam logic AXIS_USER_TIE  = 1'b0;

endpackage

// File: rtl/axis_img_source_if.sv
// AXI-Stream bundle carrying one pixel per beat, row-major, tlast on the last pixel of each row.
interface axis_img_source_if #(
    parameter int AXIS_DATA_WIDTH = 32
);
    logic                           tvalid;
    logic                           tready;
    logic [AXIS_DATA_WIDTH-1:0]     tdata;
    logic [AXIS_DATA_WIDTH/8-1:0]   tkeep;
    logic [AXIS_DATA_WIDTH/8-1:0]   tstrb;
    logic                           tlast;
    logic                           tid;
    logic                           tdest;
    logic                           user;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, user,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, user,
        output tready
    );
endinterface

// File: rtl/axis_pref_fifo.sv
// Two-entry prefetch FIFO holding pixel data plus its end-of-row flag.
module axis_pref_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);
    logic [DATA_W-1:0] data_q [2];
    logic              last_q [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count_q;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count_q == 2'd0);
    assign full    = (count_q == 2'd2);
    assign count   = count_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign head_data = data_q[rd_ptr];
    assign head_last = last_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            data_q[wr_ptr] <= push_data;
            last_q[wr_ptr] <= push_last;
        end
    end
endmodule

// File: rtl/axis_img_source.sv
// Streams a frame from a 1-cycle-latency frame memory as AXI-Stream, one pixel per beat.
module axis_img_source
    import axis_img_source_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int SRC_IMG_WIDTH   = 1920,
    parameter int SRC_IMG_HEIGHT  = 1080,
    parameter int MEM_ADDR_WIDTH  = $clog2(SRC_IMG_WIDTH*SRC_IMG_HEIGHT),
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_WIDTH-1:0]       beat_cnt,
    output logic                       mem_rd,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_raddr,
    input  logic [AXIS_DATA_WIDTH-1:0] mem_rdata,
    axis_img_source_if.master          m_axis
);
    localparam int COL_W = (SRC_IMG_WIDTH  > 1) ? $clog2(SRC_IMG_WIDTH)  : 1;
    localparam int ROW_W = (SRC_IMG_HEIGHT > 1) ? $clog2(SRC_IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SRC_IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SRC_IMG_HEIGHT - 1);

    src_state_e                 state;
    logic [MEM_ADDR_WIDTH-1:0]  addr;
    logic [COL_W-1:0]           col;
    logic [ROW_W-1:0]           row;
    logic                       rd_vld_p1;
    logic                       rd_last_p1;
    logic [AXIS_DATA_WIDTH-1:0] fifo_data;
    logic                       fifo_last;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [1:0]                 fifo_count;
    logic                       pop;
    logic                       last_hs;
    logic [2:0]                 occ_after;

    assign pop = ~fifo_empty & m_axis.tready;

    // Occupancy after this edge plus the read whose data is already on mem_rdata;
    // a new read is only issued if its data is guaranteed a FIFO slot.
    assign occ_after = {1'b0, fifo_count} + {2'b00, rd_vld_p1} - {2'b00, pop};
    assign mem_rd    = ~rst & (state == ST_FETCH) & (occ_after < 3'd2) & (~fifo_full | pop);
    assign mem_raddr = addr;

    assign last_hs = pop & (state == ST_DRAIN) & (fifo_count == 2'd1) & ~rd_vld_p1;

    // Read-return stage: data is on mem_rdata one cycle after mem_rd.
    always_ff @(posedge clk) begin
        if (rst) rd_vld_p1 <= 1'b0;
        else     rd_vld_p1 <= mem_rd;
    end

    always_ff @(posedge clk) begin
        rd_last_p1 <= (col == COL_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            beat_cnt <= '0;
            addr     <= '0;
            col      <= '0;
            row      <= '0;
        end else begin
            done <= 1'b0;
            if (pop) beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                        addr     <= '0;
                        col      <= '0;
                        row      <= '0;
                    end
                end
                ST_FETCH: begin
                    if (mem_rd) begin
                        if (col == COL_LAST && row == ROW_LAST) begin
                            state <= ST_DRAIN;
                        end else begin
                            addr <= addr + MEM_ADDR_WIDTH'(1);
                            if (col == COL_LAST) begin
                                col <= '0;
                                row <= row + ROW_W'(1);
                            end else begin
                                col <= col + COL_W'(1);
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_hs) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    axis_pref_fifo #(
        .DATA_W (AXIS_DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_vld_p1),
        .push_data (mem_rdata),
        .push_last (rd_last_p1),
        .pop       (pop),
        .head_data (fifo_data),
        .head_last (fifo_last),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_axis.tvalid = ~fifo_empty;
    assign m_axis.tdata  = fifo_empty ? '0 : fifo_data;
    assign m_axis.tlast  = ~fifo_empty & fifo_last;
    assign m_axis.tkeep  = '1;
    assign m_axis.tstrb  = '1;
    assign m_axis.tid    = AXIS_TID_TIE;
    assign m_axis.tdest  = AXIS_TDEST_TIE;
    assign m_axis.user   = AXIS_USER_TIE;
endmodule

// File: tb/tb_axis_img_source.sv
// Bench for axis_img_source: small 4x2 frame, randomized data and back-pressure, reference order model.
module tb_axis_img_source;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int DW = 32;
    localparam int AW = $clog2(N);
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [CW-1:0] beat_cnt;
    logic          mem_rd;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata = '0;
    logic          tready_r = 1'b0;

    axis_img_source_if #(.AXIS_DATA_WIDTH(DW)) axis_if ();
    assign axis_if.tready = tready_r;

    axis_img_source #(
        .AXIS_DATA_WIDTH (DW),
        .SRC_IMG_WIDTH   (W),
        .SRC_IMG_HEIGHT  (H),
        .MEM_ADDR_WIDTH  (AW),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .beat_cnt  (beat_cnt),
        .mem_rd    (mem_rd),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .m_axis    (axis_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem      [N];
    logic [DW-1:0] exp_data [N];

    function automatic bit exp_last(input int i);
        return (i % W) == (W - 1);
    endfunction

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_raddr];
    end

    int cyc = 0;
    int rdy_mode = 0;
    int rdy_low_until = 0;
    always @(posedge clk) begin
        cyc++;
        #1;
        case (rdy_mode)
            1:       tready_r = ~tready_r;
            2:       tready_r = 1'($urandom_range(0, 1));
            3:       tready_r = (cyc >= rdy_low_until);
            default: tready_r = 1'b1;
        endcase
    end

    logic [DW-1:0] got_data [$];
    bit            got_last [$];
    int            got_cyc  [$];
    int            rd_cnt = 0;
    int            done_cnt = 0;
    int            stab_err = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(negedge clk) begin
        if (mem_rd) rd_cnt++;
        if (done) done_cnt++;
        if (prev_stall && !rst &&
            (axis_if.tvalid !== 1'b1 || axis_if.tdata !== prev_data || axis_if.tlast !== prev_last))
            stab_err++;
        prev_stall = axis_if.tvalid && !axis_if.tready && !rst;
        prev_data  = axis_if.tdata;
        prev_last  = axis_if.tlast;
        if (axis_if.tvalid && axis_if.tready && !rst) begin
            got_data.push_back(axis_if.tdata);
            got_last.push_back(axis_if.tlast);
            got_cyc.push_back(cyc);
        end
    end

    task automatic load_mem(input bit rnd);
        for (int i = 0; i < N; i++) begin
            mem[i]      = rnd ? DW'($urandom) : DW'(i);
            exp_data[i] = mem[i];
        end
    endtask

    task automatic pulse_start(output int acc);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        acc   = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int lim, output bit ok);
        int t = 0;
        while (done_cnt == d0 && t < lim) begin
            @(negedge clk);
            t++;
        end
        ok = (done_cnt != d0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, mem_rd, axis_if.tvalid, axis_if.tlast} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl busy/done/mem_rd/tvalid/tlast=%b want 00000",
                     {busy, done, mem_rd, axis_if.tvalid, axis_if.tlast});
        end
        checks++;
        if (beat_cnt !== '0 || mem_raddr !== '0 || axis_if.tdata !== '0) begin
            failures++;
            $display("FAIL reset_vals beat_cnt=%0d raddr=%0d tdata=%0h want 0", beat_cnt, mem_raddr, axis_if.tdata);
        end
        checks++;
        if (axis_if.tkeep !== 4'hf || axis_if.tstrb !== 4'hf ||
            {axis_if.tid, axis_if.tdest, axis_if.user} !== 3'b0) begin
            failures++;
            $display("FAIL sideband keep=%h strb=%h id/dest/user=%b want f f 000",
                     axis_if.tkeep, axis_if.tstrb, {axis_if.tid, axis_if.tdest, axis_if.user});
        end
    endtask

    task automatic test_basic();
        int base, d0, acc;
        bit ok;
        load_mem(1'b0);
        rdy_mode = 0;
        base = got_data.size();
        d0 = done_cnt;
        pulse_start(acc);
        wait_done(d0, 100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_timeout done not seen"); end
        checks++;
        if (got_data.size() - base != N) begin
            failures++;
            $display("FAIL basic_count beats=%0d want %0d", got_data.size() - base, N);
        end
        for (int i = 0; i < N && base + i < got_data.size(); i++) begin
            checks++;
            if (got_data[base+i] !== exp_data[i] || got_last[base+i] !== exp_last(i) ||
                got_cyc[base+i] != acc + 2 + i) begin
                failures++;
                $display("FAIL basic_beat%0d data=%0h last=%0b cyc=%0d want %0h %0b %0d", i,
                         got_data[base+i], got_last[base+i], got_cyc[base+i], exp_data[i], exp_last(i), acc + 2 + i);
            end
        end
        checks++;
        if (done_cnt - d0 != 1 || beat_cnt !== CW'(N) || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_end dones=%0d beat_cnt=%0d busy=%0b want 1 %0d 0", done_cnt - d0, beat_cnt, busy, N);
        end
    endtask

    task automatic test_toggle();
        int base, d0, s0, acc;
        bit ok;
        rdy_mode = 1;
        base = got_data.size();
        d0 = done_cnt;
        s0 = stab_err;
        pulse_start(acc);
        wait_done(d0, 200, ok);
        checks++;
        if (!ok || got_data.size() - base != N) begin
            failures++;
            $display("FAIL toggle_count done=%0b beats=%0d want 1 %0d", ok, got_data.size() - base, N);
        end
        for (int i = 0; i < N && base + i < got_data.size(); i++) begin
            checks++;
            if (got_data[base+i] !== exp_data[i] || got_last[base+i] !== exp_last(i)) begin
                failures++;
                $display("FAIL toggle_beat%0d data=%0h last=%0b want %0h %0b", i,
                         got_data[base+i], got_last[base+i], exp_data[i], exp_last(i));
            end
        end
        checks++;
        if (stab_err != s0) begin
            failures++;
            $display("FAIL toggle_stable violations=%0d want 0", stab_err - s0);
        end
    endtask

    task automatic test_stall();
        int base, d0, acc, nrd, bad, t;
        bit ok;
        rdy_mode = 3;
        rdy_low_until = cyc + 22;
        base = got_data.size();
        d0 = done_cnt;
        pulse_start(acc);
        nrd = 0; bad = 0; t = 0;
        @(negedge clk);
        while (!axis_if.tready && t < 40) begin
            if (mem_rd) nrd++;
            if (cyc >= acc + 2 && (axis_if.tvalid !== 1'b1 || axis_if.tdata !== '0 || axis_if.tlast !== 1'b0)) bad++;
            @(negedge clk);
            t++;
        end
        checks++;
        if (nrd < 1 || nrd > 3) begin
            failures++;
            $display("FAIL stall_reads issued=%0d want 1..3", nrd);
        end
        checks++;
        if (bad != 0 || t < 18) begin
            failures++;
            $display("FAIL stall_hold bad_cycles=%0d stall_len=%0d want 0 and >=18", bad, t);
        end
        wait_done(d0, 200, ok);
        checks++;
        if (!ok || got_data.size() - base != N) begin
            failures++;
            $display("FAIL stall_count done=%0b beats=%0d want 1 %0d", ok, got_data.size() - base, N);
        end
        for (int i = 0; i < N && base + i < got_data.size(); i++) begin
            checks++;
            if (got_data[base+i] !== exp_data[i] || got_last[base+i] !== exp_last(i)) begin
                failures++;
                $display("FAIL stall_beat%0d data=%0h last=%0b want %0h %0b", i,
                         got_data[base+i], got_last[base+i], exp_data[i], exp_last(i));
            end
        end
        rdy_mode = 0;
    endtask

    task automatic test_start_busy();
        int base, d0, acc, acc2, t;
        bit ok;
        rdy_mode = 0;
        base = got_data.size();
        d0 = done_cnt;
        pulse_start(acc);
        t = 0;
        while (got_data.size() < base + 3 && t < 50) begin @(negedge clk); t++; end
        pulse_start(acc2);
        wait_done(d0, 100, ok);
        repeat (15) @(negedge clk);
        checks++;
        if (got_data.size() - base != N || done_cnt - d0 != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_start beats=%0d dones=%0d busy=%0b want %0d 1 0",
                     got_data.size() - base, done_cnt - d0, busy, N);
        end
    endtask

    task automatic test_reset_mid();
        int base, d0, acc, t;
        bit ok;
        rdy_mode = 0;
        base = got_data.size();
        pulse_start(acc);
        t = 0;
        while (got_data.size() < base + 5 && t < 50) begin @(negedge clk); t++; end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, mem_rd, axis_if.tvalid, axis_if.tlast} !== 5'b0) begin
            failures++;
            $display("FAIL midrst_ctrl busy/done/mem_rd/tvalid/tlast=%b want 00000",
                     {busy, done, mem_rd, axis_if.tvalid, axis_if.tlast});
        end
        checks++;
        if (beat_cnt !== '0 || mem_raddr !== '0 || axis_if.tdata !== '0) begin
            failures++;
            $display("FAIL midrst_vals beat_cnt=%0d raddr=%0d tdata=%0h want 0", beat_cnt, mem_raddr, axis_if.tdata);
        end
        repeat (3) @(negedge clk);
        base = got_data.size();
        d0 = done_cnt;
        pulse_start(acc);
        wait_done(d0, 100, ok);
        checks++;
        if (!ok || got_data.size() - base != N) begin
            failures++;
            $display("FAIL midrst_count done=%0b beats=%0d want 1 %0d", ok, got_data.size() - base, N);
        end
        for (int i = 0; i < N && base + i < got_data.size(); i++) begin
            checks++;
            if (got_data[base+i] !== exp_data[i] || got_last[base+i] !== exp_last(i)) begin
                failures++;
                $display("FAIL midrst_beat%0d data=%0h last=%0b want %0h %0b", i,
                         got_data[base+i], got_last[base+i], exp_data[i], exp_last(i));
            end
        end
    endtask

    task automatic test_done_start();
        int base, d0, acc, acc2, t;
        bit ok;
        load_mem(1'b1);
        rdy_mode = 0;
        base = got_data.size();
        d0 = done_cnt;
        pulse_start(acc);
        t = 0;
        @(negedge clk);
        while (done !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL dstart_timeout done=%b want 1", done); end
        start = 1'b1;
        @(posedge clk); #1;
        acc2  = cyc;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (beat_cnt !== '0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL dstart_restart beat_cnt=%0d busy=%0b want 0 1", beat_cnt, busy);
        end
        wait_done(d0 + 1, 100, ok);
        checks++;
        if (!ok || got_data.size() - base != 2 * N || done_cnt - d0 != 2) begin
            failures++;
            $display("FAIL dstart_count beats=%0d dones=%0d want %0d 2", got_data.size() - base, done_cnt - d0, 2 * N);
        end
        for (int i = 0; i < 2 * N && base + i < got_data.size(); i++) begin
            checks++;
            if (got_data[base+i] !== exp_data[i % N] || got_last[base+i] !== exp_last(i % N)) begin
                failures++;
                $display("FAIL dstart_beat%0d data=%0h last=%0b want %0h %0b", i,
                         got_data[base+i], got_last[base+i], exp_data[i % N], exp_last(i % N));
            end
        end
        checks++;
        if (got_data.size() > base + N && got_cyc[base+N] - acc2 > 2) begin
            failures++;
            $display("FAIL dstart_gap first_beat_after=%0d cycles want <=2", got_cyc[base+N] - acc2);
        end
    endtask

    task automatic test_random();
        int base, d0, s0, acc;
        bit ok;
        load_mem(1'b1);
        rdy_mode = 2;
        base = got_data.size();
        d0 = done_cnt;
        s0 = stab_err;
        for (int f = 0; f < 2; f++) begin
            pulse_start(acc);
            wait_done(d0 + f, 300, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL rand_timeout frame=%0d", f); end
        end
        checks++;
        if (got_data.size() - base != 2 * N || beat_cnt !== CW'(N)) begin
            failures++;
            $display("FAIL rand_count beats=%0d beat_cnt=%0d want %0d %0d", got_data.size() - base, beat_cnt, 2 * N, N);
        end
        for (int i = 0; i < 2 * N && base + i < got_data.size(); i++) begin
            checks++;
            if (got_data[base+i] !== exp_data[i % N] || got_last[base+i] !== exp_last(i % N)) begin
                failures++;
                $display("FAIL rand_beat%0d data=%0h last=%0b want %0h %0b", i,
                         got_data[base+i], got_last[base+i], exp_data[i % N], exp_last(i % N));
            end
        end
        checks++;
        if (stab_err != s0) begin
            failures++;
            $display("FAIL rand_stable violations=%0d want 0", stab_err - s0);
        end
        rdy_mode = 0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_basic();
        test_toggle();
        test_stall();
        test_start_busy();
        test_reset_mid();
        test_done_start();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
